// File: rtl/vp_spec_if.sv
// vp_spec_if: pipeline-facing bundle of the load-value speculation sequencer
// Inputs to the sequencer: load-miss request, prediction, EX memory-op flag, D-cache fill.
// Outputs from the sequencer: snapshot/recover, MEM mux, D-cache hold, stall/flush,
// PC redirect, predictor training and saturating statistics.
interface vp_spec_if #(parameter int DATA_WIDTH = 32, parameter int CNT_W = 16);
  logic                  lmiss_valid;
  logic [DATA_WIDTH-1:0] lmiss_pc;
  logic [DATA_WIDTH-1:0] lmiss_addr;
  logic                  pred_valid;
  logic [DATA_WIDTH-1:0] pred_value;
  logic                  mem_access_ex;
  logic                  dc_resp_valid;
  logic [DATA_WIDTH-1:0] dc_resp_data;
  logic                  snapshot_take;
  logic                  use_pred;
  logic [DATA_WIDTH-1:0] pred_data;
  logic                  dc_hold;
  logic [DATA_WIDTH-1:0] dc_hold_addr;
  logic                  stall_all;
  logic                  recover;
  logic                  flush_all;
  logic                  load_pc_we;
  logic [DATA_WIDTH-1:0] load_pc;
  logic                  train_valid;
  logic                  train_correct;
  logic                  spec_active;
  logic [CNT_W-1:0]      stat_spec;
  logic [CNT_W-1:0]      stat_mispred;
  modport master (
    output lmiss_valid, lmiss_pc, lmiss_addr, pred_valid, pred_value, mem_access_ex,
           dc_resp_valid, dc_resp_data,
    input  snapshot_take, use_pred, pred_data, dc_hold, dc_hold_addr, stall_all, recover,
           flush_all, load_pc_we, load_pc, train_valid, train_correct, spec_active,
           stat_spec, stat_mispred
  );
  modport slave (
    input  lmiss_valid, lmiss_pc, lmiss_addr, pred_valid, pred_value, mem_access_ex,
           dc_resp_valid, dc_resp_data,
    output snapshot_take, use_pred, pred_data, dc_hold, dc_hold_addr, stall_all, recover,
           flush_all, load_pc_we, load_pc, train_valid, train_correct, spec_active,
           stat_spec, stat_mispred
  );
endinterface

// File: rtl/vp_spec_sequencer.sv
// vp_spec_sequencer: sequences one load-value speculation episode beside the hazard unit
// Ports: clk, rst_n (async, active-low), bus (vp_spec_if.slave) carrying the load miss,
// prediction, fill response and all speculation control/statistics outputs.
module vp_spec_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input logic   clk,
  input logic   rst_n,
  vp_spec_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, SNAP, SPEC, HOLD, FLUSH, REDIRECT} state_t;
  state_t                state_q, state_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d, addr_q, addr_d, pred_q, pred_d;
  logic [CNT_W-1:0]      stat_spec_q, stat_spec_d, stat_mispred_q, stat_mispred_d;
  logic                  train_valid_q, train_valid_d, train_correct_q, train_correct_d;
  logic                  waiting, hit, timeout, start;
  always_comb begin
    waiting = state_q == SPEC || state_q == HOLD;
    hit     = bus.dc_resp_data == pred_q;
    timeout = cnt_q == TW'(TIMEOUT_CYCLES - 1);
    start   = state_q == IDLE && bus.lmiss_valid && bus.pred_valid;
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = start ? SNAP : IDLE;
      SNAP:       state_d = SPEC;
      // a fill arriving on the timeout cycle still gets verified normally
      SPEC, HOLD: state_d = bus.dc_resp_valid ? (hit ? IDLE : FLUSH) : timeout ? FLUSH :
                            (state_q == HOLD || bus.mem_access_ex) ? HOLD : SPEC;
      FLUSH:      state_d = REDIRECT;
      default:    state_d = IDLE;
    endcase
    cnt_d           = state_q == SNAP ? '0 : waiting ? cnt_q + 1'b1 : cnt_q;
    pc_d            = start ? bus.lmiss_pc : pc_q;
    addr_d          = start ? bus.lmiss_addr : addr_q;
    pred_d          = start ? bus.pred_value : pred_q;
    stat_spec_d     = stat_spec_q + CNT_W'(start && !(&stat_spec_q));
    stat_mispred_d  = stat_mispred_q + CNT_W'(state_q == FLUSH && !(&stat_mispred_q));
    train_valid_d   = waiting && (bus.dc_resp_valid || timeout);
    train_correct_d = waiting && bus.dc_resp_valid && hit;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      pc_q            <= '0;
      addr_q          <= '0;
      pred_q          <= '0;
      stat_spec_q     <= '0;
      stat_mispred_q  <= '0;
      train_valid_q   <= 1'b0;
      train_correct_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pc_q            <= pc_d;
      addr_q          <= addr_d;
      pred_q          <= pred_d;
      stat_spec_q     <= stat_spec_d;
      stat_mispred_q  <= stat_mispred_d;
      train_valid_q   <= train_valid_d;
      train_correct_q <= train_correct_d;
    end
  assign bus.snapshot_take = state_q == SNAP;
  assign bus.use_pred      = state_q == SNAP;
  assign bus.pred_data     = pred_q;
  assign bus.dc_hold       = state_q == SNAP || waiting;
  assign bus.dc_hold_addr  = addr_q;
  assign bus.stall_all     = state_q == HOLD;
  assign bus.recover       = state_q == FLUSH;
  assign bus.flush_all     = state_q == FLUSH || state_q == REDIRECT;
  assign bus.load_pc_we    = state_q == REDIRECT;
  assign bus.load_pc       = pc_q;
  assign bus.train_valid   = train_valid_q;
  assign bus.train_correct = train_correct_q;
  assign bus.spec_active   = state_q != IDLE;
  assign bus.stat_spec     = stat_spec_q;
  assign bus.stat_mispred  = stat_mispred_q;
endmodule

// File: tb/tb_vp_spec_sequencer.sv
// tb_vp_spec_sequencer: directed self-checking bench for vp_spec_sequencer
module tb_vp_spec_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  vp_spec_if #(.DATA_WIDTH(32), .CNT_W(4)) bus ();
  vp_spec_sequencer #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(64), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] pred);
    bus.lmiss_valid = 1'b1;
    bus.pred_valid  = 1'b1;
    bus.lmiss_pc    = pc;
    bus.lmiss_addr  = addr;
    bus.pred_value  = pred;
    tick();
    bus.lmiss_valid = 1'b0;
    bus.pred_valid  = 1'b0;
  endtask
  function automatic logic [173:0] all_out();
    return {bus.snapshot_take, bus.use_pred, bus.pred_data, bus.dc_hold, bus.dc_hold_addr,
            bus.stall_all, bus.recover, bus.flush_all, bus.load_pc_we, bus.load_pc,
            bus.train_valid, bus.train_correct, bus.spec_active, bus.stat_spec, bus.stat_mispred};
  endfunction
  task automatic test_reset();
    bus.lmiss_valid = 0; bus.lmiss_pc = 0; bus.lmiss_addr = 0; bus.pred_valid = 0;
    bus.pred_value = 0; bus.mem_access_ex = 0; bus.dc_resp_valid = 0; bus.dc_resp_data = 0;
    tick(); tick();
    n_chk++;
    if (all_out() !== '0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", all_out()); end
    rst_n = 1'b1;
    bus.lmiss_valid = 1'b1;
    tick();
    bus.lmiss_valid = 1'b0;
    n_chk++;
    if ({bus.spec_active, bus.stat_spec} !== 5'h0) begin
      n_fail++; $display("FAIL miss_no_pred got %b/%0d want 0/0", bus.spec_active, bus.stat_spec);
    end
  endtask
  task automatic test_correct();
    launch(32'h400100, 32'h1000, 32'hAB);
    n_chk++;
    if ({bus.snapshot_take, bus.use_pred, bus.dc_hold, bus.stat_spec} !== {3'b111, 4'd1}) begin
      n_fail++; $display("FAIL snap_ctrl got %b%b%b/%0d want 111/1", bus.snapshot_take, bus.use_pred, bus.dc_hold, bus.stat_spec);
    end
    n_chk++;
    if ({bus.pred_data, bus.dc_hold_addr} !== {32'hAB, 32'h1000}) begin
      n_fail++; $display("FAIL snap_latch got %h/%h want ab/1000", bus.pred_data, bus.dc_hold_addr);
    end
    tick();
    n_chk++;
    if ({bus.snapshot_take, bus.use_pred, bus.dc_hold, bus.spec_active} !== 4'b0011) begin
      n_fail++; $display("FAIL spec_ctrl got %b%b%b%b want 0011", bus.snapshot_take, bus.use_pred, bus.dc_hold, bus.spec_active);
    end
    tick();
    tick();
    bus.dc_resp_valid = 1'b1;
    bus.dc_resp_data  = 32'hAB;
    tick();
    bus.dc_resp_valid = 1'b0;
    n_chk++;
    if ({bus.train_valid, bus.train_correct, bus.spec_active, bus.recover, bus.flush_all, bus.dc_hold} !== 6'b110000) begin
      n_fail++; $display("FAIL correct_resume got %b%b%b%b%b%b want 110000", bus.train_valid, bus.train_correct, bus.spec_active, bus.recover, bus.flush_all, bus.dc_hold);
    end
    tick();
    n_chk++;
    if (bus.train_valid !== 1'b0) begin n_fail++; $display("FAIL train_pulse_len got %b want 0", bus.train_valid); end
  endtask
  task automatic test_mispredict();
    launch(32'h400100, 32'h1000, 32'hAB);
    tick(); tick(); tick();
    bus.dc_resp_valid = 1'b1;
    bus.dc_resp_data  = 32'hAC;
    tick();
    bus.dc_resp_valid = 1'b0;
    n_chk++;
    if ({bus.recover, bus.flush_all, bus.load_pc_we, bus.train_valid, bus.train_correct} !== 5'b11010) begin
      n_fail++; $display("FAIL flush_state got %b%b%b%b%b want 11010", bus.recover, bus.flush_all, bus.load_pc_we, bus.train_valid, bus.train_correct);
    end
    tick();
    n_chk++;
    if ({bus.recover, bus.flush_all, bus.load_pc_we, bus.train_valid} !== 4'b0110 || bus.load_pc !== 32'h400100) begin
      n_fail++; $display("FAIL redirect_state got %b%b%b%b pc %h want 0110 pc 400100", bus.recover, bus.flush_all, bus.load_pc_we, bus.train_valid, bus.load_pc);
    end
    n_chk++;
    if ({bus.stat_spec, bus.stat_mispred} !== {4'd2, 4'd1}) begin
      n_fail++; $display("FAIL mispred_stats got %0d/%0d want 2/1", bus.stat_spec, bus.stat_mispred);
    end
    tick();
    n_chk++;
    if ({bus.flush_all, bus.load_pc_we, bus.spec_active} !== 3'b000) begin
      n_fail++; $display("FAIL after_redirect got %b%b%b want 000", bus.flush_all, bus.load_pc_we, bus.spec_active);
    end
  endtask
  task automatic test_hold();
    launch(32'h400200, 32'h2000, 32'h1234);
    tick();
    bus.mem_access_ex = 1'b1;
    n_chk++;
    if (bus.stall_all !== 1'b0) begin n_fail++; $display("FAIL spec_no_stall got %b want 0", bus.stall_all); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      bus.mem_access_ex = 1'b0;
      if (i == 4) begin bus.dc_resp_valid = 1'b1; bus.dc_resp_data = 32'h1234; end
      n_chk++;
      if ({bus.stall_all, bus.dc_hold} !== 2'b11) begin
        n_fail++; $display("FAIL hold_stall_%0d got %b%b want 11", i, bus.stall_all, bus.dc_hold);
      end
    end
    tick();
    bus.dc_resp_valid = 1'b0;
    n_chk++;
    if ({bus.stall_all, bus.spec_active, bus.train_valid, bus.train_correct, bus.stat_spec} !== {4'b0011, 4'd3}) begin
      n_fail++; $display("FAIL hold_resume got %b%b%b%b/%0d want 0011/3", bus.stall_all, bus.spec_active, bus.train_valid, bus.train_correct, bus.stat_spec);
    end
  endtask
  task automatic test_timeout();
    int early;
    early = 0;
    launch(32'h400300, 32'h3000, 32'h55);
    for (int i = 0; i < 64; i++) begin
      tick();
      if (bus.flush_all !== 1'b0 || bus.dc_hold !== 1'b1) early++;
    end
    n_chk++;
    if (early != 0) begin n_fail++; $display("FAIL timeout_early got %0d bad cycles want 0", early); end
    tick();
    n_chk++;
    if ({bus.recover, bus.flush_all, bus.train_valid, bus.train_correct} !== 4'b1110) begin
      n_fail++; $display("FAIL timeout_flush got %b%b%b%b want 1110", bus.recover, bus.flush_all, bus.train_valid, bus.train_correct);
    end
    tick();
    n_chk++;
    if (bus.load_pc_we !== 1'b1 || bus.load_pc !== 32'h400300 || bus.stat_mispred !== 4'd2) begin
      n_fail++; $display("FAIL timeout_redirect got we %b pc %h mis %0d want 1 400300 2", bus.load_pc_we, bus.load_pc, bus.stat_mispred);
    end
    tick();
    launch(32'h400400, 32'h4000, 32'h66);
    for (int i = 0; i < 64; i++) begin
      tick();
      if (i == 63) begin bus.dc_resp_valid = 1'b1; bus.dc_resp_data = 32'h66; end
    end
    tick();
    bus.dc_resp_valid = 1'b0;
    n_chk++;
    if ({bus.recover, bus.spec_active, bus.train_valid, bus.train_correct} !== 4'b0011 || {bus.stat_spec, bus.stat_mispred} !== {4'd5, 4'd2}) begin
      n_fail++; $display("FAIL resp_on_timeout got %b%b%b%b %0d/%0d want 0011 5/2", bus.recover, bus.spec_active, bus.train_valid, bus.train_correct, bus.stat_spec, bus.stat_mispred);
    end
  endtask
  task automatic test_reset_abort();
    launch(32'h400500, 32'h5000, 32'h77);
    tick();
    bus.lmiss_valid = 1'b1; bus.pred_valid = 1'b1;
    bus.lmiss_pc = 32'h999; bus.lmiss_addr = 32'h9999; bus.pred_value = 32'h88;
    tick();
    bus.lmiss_valid = 1'b0; bus.pred_valid = 1'b0;
    n_chk++;
    if ({bus.dc_hold_addr, bus.pred_data, bus.load_pc} !== {32'h5000, 32'h77, 32'h400500} || bus.stat_spec !== 4'd6) begin
      n_fail++; $display("FAIL lmiss_in_spec got %h %h %h %0d want 5000 77 400500 6", bus.dc_hold_addr, bus.pred_data, bus.load_pc, bus.stat_spec);
    end
    bus.mem_access_ex = 1'b1;
    tick();
    bus.mem_access_ex = 1'b0;
    n_chk++;
    if (bus.stall_all !== 1'b1) begin n_fail++; $display("FAIL abort_in_hold got %b want 1", bus.stall_all); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (all_out() !== '0) begin n_fail++; $display("FAIL async_reset got %h want 0", all_out()); end
    tick(); tick();
    n_chk++;
    if ({bus.recover, bus.spec_active, bus.flush_all} !== 3'b000) begin
      n_fail++; $display("FAIL reset_no_recover got %b%b%b want 000", bus.recover, bus.spec_active, bus.flush_all);
    end
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_saturation();
    for (int i = 1; i <= 17; i++) begin
      launch(32'h400600 + i, 32'h6000, 32'(i));
      tick();
      bus.dc_resp_valid = 1'b1;
      bus.dc_resp_data  = 32'(i);
      tick();
      bus.dc_resp_valid = 1'b0;
      if (i == 15 || i == 17) begin
        n_chk++;
        if (bus.stat_spec !== 4'd15) begin n_fail++; $display("FAIL stat_sat_%0d got %0d want 15", i, bus.stat_spec); end
      end
    end
    n_chk++;
    if (bus.stat_mispred !== 4'd0) begin n_fail++; $display("FAIL sat_mispred got %0d want 0", bus.stat_mispred); end
  endtask
  initial begin
    test_reset();
    test_correct();
    test_mispredict();
    test_hold();
    test_timeout();
    test_reset_abort();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
